// File: rtl/aibnd_str_clktree_seq.sv
// aibnd_str_clktree_seq: strobe clock tree with grouped req/ack enable ramp for the AIB slave datapath
//
// Fans clkin out to NUM_L left lanes, NUM_R right lanes, one DLL replica load and three mimic
// loads. Lane groups (GRP lanes per side each) are switched on one at a time every STEP_CYC
// cycles and switched off in reverse order, which spreads the supply current step.
//
// Optional build macro: STRCLK_SKEW_MODEL_EN adds an equal #SKEW_DELAY ps transport delay
// to every clock output. Without it, the outputs follow the gates with zero delay.
//
// Ports
//   clkin           in   clock source and sequencer clock
//   rst             in   synchronous reset, active-high
//   en_req          in   level request, 1 = tree on, 0 = tree off
//   en_ack          out  high only while the whole tree is on
//   busy            out  high while ramping up or down
//   lane_mask_l     in   left lanes allowed to run, captured when leaving idle
//   lane_mask_r     in   right lanes allowed to run, captured when leaving idle
//   lstrbclk_l      out  gated left lane clocks
//   lstrbclk_r      out  gated right lane clocks
//   lstrbclk_rep    out  DLL replica clock, follows group 0
//   lstrbclk_mimic  out  mimic load clocks, follow group 0
`timescale 1ps/1ps
module aibnd_str_clktree_seq #(
    parameter int NUM_L      = 12,
    parameter int NUM_R      = 12,
    parameter int GRP        = 2,
    parameter int STEP_CYC   = 4,
    parameter int SKEW_DELAY = 60
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             en_req,
    output logic             en_ack,
    output logic             busy,
    input  logic [NUM_L-1:0] lane_mask_l,
    input  logic [NUM_R-1:0] lane_mask_r,
    output logic [NUM_L-1:0] lstrbclk_l,
    output logic [NUM_R-1:0] lstrbclk_r,
    output logic             lstrbclk_rep,
    output logic [2:0]       lstrbclk_mimic
);
    localparam int MAXN  = (NUM_L > NUM_R) ? NUM_L : NUM_R;
    localparam int NSTEP = (MAXN + GRP - 1) / GRP;
    localparam int CW    = $clog2(STEP_CYC + 1);
    localparam logic [CW-1:0]    LAST = CW'(STEP_CYC - 1);
    localparam logic [NSTEP-1:0] G0   = NSTEP'(1);

    typedef enum logic [1:0] {IDLE, RAMP_UP, ON, RAMP_DN} state_t;

    state_t           state, state_n;
    logic [NSTEP-1:0] grp_en, grp_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [NUM_L-1:0] mask_l_q, mask_l_n;
    logic [NUM_R-1:0] mask_r_q, mask_r_n;
    logic             step;

    always_ff @(posedge clkin) begin
        if (rst) begin
            state    <= IDLE;
            grp_en   <= '0;
            cnt      <= '0;
            mask_l_q <= '0;
            mask_r_q <= '0;
        end else begin
            state    <= state_n;
            grp_en   <= grp_n;
            cnt      <= cnt_n;
            mask_l_q <= mask_l_n;
            mask_r_q <= mask_r_n;
        end
    end

    // grp_en is a thermometer code: ramp-up fills from bit 0, ramp-down drains from the top
    always_comb begin
        state_n  = state;
        grp_n    = grp_en;
        cnt_n    = cnt;
        mask_l_n = mask_l_q;
        mask_r_n = mask_r_q;
        step     = (cnt == LAST);
        case (state)
            IDLE: begin
                if (en_req) begin
                    mask_l_n = lane_mask_l;
                    mask_r_n = lane_mask_r;
                    grp_n    = G0;
                    cnt_n    = '0;
                    state_n  = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (!en_req) begin
                    cnt_n   = '0;
                    state_n = RAMP_DN;
                end else if (step) begin
                    cnt_n = '0;
                    if (&grp_en) state_n = ON;
                    else grp_n = (grp_en << 1) | G0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ON: begin
                if (!en_req) begin
                    cnt_n   = '0;
                    state_n = RAMP_DN;
                end
            end
            RAMP_DN: begin
                if (en_req) begin
                    // resume from the current level; group 0 is forced on so the ramp restarts live
                    grp_n   = grp_en | G0;
                    cnt_n   = '0;
                    state_n = RAMP_UP;
                end else if (step) begin
                    grp_n = grp_en >> 1;
                    cnt_n = '0;
                    if ((grp_en >> 1) == '0) state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign en_ack = (state == ON);
    assign busy   = (state == RAMP_UP) || (state == RAMP_DN);

    logic [NUM_L-1:0] gate_l, lat_l, raw_l;
    logic [NUM_R-1:0] gate_r, lat_r, raw_r;
    logic             gate_rep, lat_rep, raw_rep;

    // rst also forces the gates off so outputs stay low from the first low phase of reset
    for (genvar i = 0; i < NUM_L; i++) begin : g_gate_l
        assign gate_l[i] = grp_en[i / GRP] & mask_l_q[i] & ~rst;
    end
    for (genvar i = 0; i < NUM_R; i++) begin : g_gate_r
        assign gate_r[i] = grp_en[i / GRP] & mask_r_q[i] & ~rst;
    end
    assign gate_rep = grp_en[0] & ~rst;

    // ICG model: enables only move while clkin is low, so each output pulse is whole
    always_latch begin
        if (!clkin) begin
            lat_l   <= gate_l;
            lat_r   <= gate_r;
            lat_rep <= gate_rep;
        end
    end

    assign raw_l   = {NUM_L{clkin}} & lat_l;
    assign raw_r   = {NUM_R{clkin}} & lat_r;
    assign raw_rep = clkin & lat_rep;

`ifdef STRCLK_SKEW_MODEL_EN
    // identical per-edge transport delay on every output keeps inter-lane skew at zero
    always @(raw_l)   lstrbclk_l     <= #SKEW_DELAY raw_l;
    always @(raw_r)   lstrbclk_r     <= #SKEW_DELAY raw_r;
    always @(raw_rep) lstrbclk_rep   <= #SKEW_DELAY raw_rep;
    always @(raw_rep) lstrbclk_mimic <= #SKEW_DELAY {3{raw_rep}};
`else
    assign lstrbclk_l     = raw_l;
    assign lstrbclk_r     = raw_r;
    assign lstrbclk_rep   = raw_rep;
    assign lstrbclk_mimic = {3{raw_rep}};
    // SKEW_DELAY only shapes the delayed build; a negative value is meaningless in either
    if (SKEW_DELAY < 0) begin : g_skew_unused
    end
`endif
endmodule
